// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory access arbiter.
// FSM states, address regions, region tags and requester port IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_TURN
  } state_e;

  typedef enum logic [1:0] {
    RGN_ROM,
    RGN_RAM,
    RGN_UNMAPPED
  } region_e;

  localparam logic [2:0] TAG_ROM = 3'b000;
  localparam logic [2:0] TAG_RAM = 3'b001;

  typedef enum logic {
    PORT_IF,
    PORT_LS
  } port_e;

endpackage

// File: rtl/mem_region_decode.sv
// mem_region_decode: maps addr[15:13] to a region, its wait count and
// an error flag (unmapped, or store to ROM). Ports: addr_i, we_i -> region_o, err_o, wait_o.
module mem_region_decode
  import mem_arb_pkg::*;
#(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 0
) (
  input  logic [15:0] addr_i,
  input  logic        we_i,
  output region_e     region_o,
  output logic        err_o,
  output logic [3:0]  wait_o
);

  logic unused_lo;
  assign unused_lo = ^addr_i[12:0];

  always_comb begin
    region_o = RGN_UNMAPPED;
    err_o    = 1'b1;
    wait_o   = '0;
    unique case (1'b1)
      (addr_i[15:13] == TAG_ROM): begin
        region_o = RGN_ROM;
        err_o    = we_i;
        wait_o   = 4'(ROM_WAIT);
      end
      (addr_i[15:13] == TAG_RAM): begin
        region_o = RGN_RAM;
        err_o    = 1'b0;
        wait_o   = 4'(RAM_WAIT);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one memory port between fetch and load/store.
// Ports: if_* / ls_* requester handshakes, mem_* strobes/addr/data, busy.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ROM_WAIT   = 1,
  parameter int unsigned RAM_WAIT   = 0,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [7:0]  if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [15:0] ls_addr,
  input  logic [7:0]  ls_wdata,
  output logic        ls_ack,
  output logic [7:0]  ls_rdata,
  output logic        ls_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  localparam logic [3:0] MAX_S = 4'(MAX_STREAK);

  state_e      state_q, state_d;
  port_e       port_q, port_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        if_ack_q, if_ack_d;
  logic        ls_ack_q, ls_ack_d;
  logic        if_err_q, if_err_d;
  logic        ls_err_q, ls_err_d;
  logic [7:0]  if_rdata_q, if_rdata_d;
  logic [7:0]  ls_rdata_q, ls_rdata_d;

  logic        pick_if;
  logic [15:0] sel_addr;
  logic        sel_we;
  region_e     dec_rgn;
  logic        dec_err;
  logic [3:0]  dec_wait;
  logic        unused_rgn;
  logic        fin;
  logic        fin_err;
  logic [7:0]  fin_data;

  // Fetch wins only when load/store is idle or has hit its streak limit.
  assign pick_if  = if_req && (!ls_req || streak_q == MAX_S);
  assign sel_addr = pick_if ? if_addr : ls_addr;
  assign sel_we   = !pick_if && ls_we;
  assign unused_rgn = ^{dec_rgn};

  mem_region_decode #(
    .ROM_WAIT (ROM_WAIT),
    .RAM_WAIT (RAM_WAIT)
  ) u_dec (
    .addr_i   (sel_addr),
    .we_i     (sel_we),
    .region_o (dec_rgn),
    .err_o    (dec_err),
    .wait_o   (dec_wait)
  );

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    if_ack_d   = 1'b0;
    ls_ack_d   = 1'b0;
    if_err_d   = if_err_q;
    ls_err_d   = ls_err_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_data   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!if_req) streak_d = '0;
        if (if_req || ls_req) begin
          port_d = pick_if ? PORT_IF : PORT_LS;
          we_d   = sel_we;
          if (pick_if)
            streak_d = '0;
          else if (if_req && streak_q != MAX_S)
            streak_d = streak_q + 4'd1;
          if (dec_err) begin
            state_d = S_DONE;
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = dec_wait;
            addr_d  = sel_addr;
            rd_d    = !sel_we;
            wr_d    = sel_we;
            if (sel_we) wdata_d = ls_wdata;
          end
        end
      end
      S_ACCESS: begin
        rd_d = rd_q;
        wr_d = wr_q;
        if (cnt_q == '0) begin
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          state_d  = S_DONE;
          fin      = 1'b1;
          fin_data = we_q ? 8'h00 : mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = we_q ? S_TURN : S_IDLE;
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Completion results are registered so ack arrives with rdata/err.
    if (fin) begin
      if (port_d == PORT_IF) begin
        if_ack_d   = 1'b1;
        if_err_d   = fin_err;
        if_rdata_d = fin_data;
      end else begin
        ls_ack_d   = 1'b1;
        ls_err_d   = fin_err;
        ls_rdata_d = fin_data;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      streak_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      if_ack_q   <= 1'b0;
      ls_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      ls_err_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      if_ack_q   <= if_ack_d;
      ls_ack_q   <= ls_ack_d;
      if_err_q   <= if_err_d;
      ls_err_q   <= ls_err_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign ls_ack    = ls_ack_q;
  assign ls_err    = ls_err_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule
